// File: rtl/reversi_pkg.sv
// Shared definitions for the reversi board renderer.
//   - Cell codes stored 3 bits per cell in the board vector.
//   - 3-bit RGB colours used by the renderer.
//   - State encoding of the drawer FSM.
package reversi_pkg;

  // Cell codes
  localparam logic [2:0] CELL_EMPTY  = 3'b000;
  localparam logic [2:0] CELL_ENABLE = 3'b100;
  localparam logic [2:0] CELL_WHITE  = 3'b110;
  localparam logic [2:0] CELL_BLACK  = 3'b111;

  // Pixel colours, {R,G,B}
  localparam logic [2:0] COL_GRID  = 3'b001;
  localparam logic [2:0] COL_FELT  = 3'b010;
  localparam logic [2:0] COL_WHITE = 3'b111;
  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_MARK  = 3'b110;
  localparam logic [2:0] COL_ERR   = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    FIN  = 2'd2
  } draw_state_t;

endpackage

// File: rtl/board_drawer_if.sv
// Board-drawer bus: board snapshot request in, pixel stream out.
//   board_result : 192-bit board, cell i at [3i+2:3i]
//   start        : one-cycle redraw request
//   vga_x/vga_y  : pixel coordinates (8 b / 7 b)
//   vga_colour   : 3-bit RGB
//   plot         : pixel write strobe
//   busy         : frame in progress
//   done         : one-cycle pulse after the last pixel
// Modports: master drives the request (board FSM / bench), slave is the drawer.
interface board_drawer_if;
  logic [191:0] board_result;
  logic         start;
  logic [7:0]   vga_x;
  logic [6:0]   vga_y;
  logic [2:0]   vga_colour;
  logic         plot;
  logic         busy;
  logic         done;

  modport master (
    output board_result, start,
    input  vga_x, vga_y, vga_colour, plot, busy, done
  );

  modport slave (
    input  board_result, start,
    output vga_x, vga_y, vga_colour, plot, busy, done
  );
endinterface

// File: rtl/cell_pixel_colour.sv
// Colour of one pixel inside a board cell.
//   code   : 3-bit cell code of the cell being drawn
//   sx, sy : pixel position inside the cell (0..CELL-1)
//   colour : 3-bit RGB result
// Rules are evaluated in priority order: grid line, disc, move marker,
// invalid-code fill, felt.
module cell_pixel_colour
  import reversi_pkg::*;
#(
  parameter int CELL = 12,
  localparam int SW = $clog2(CELL)
) (
  input  logic [2:0]    code,
  input  logic [SW-1:0] sx,
  input  logic [SW-1:0] sy,
  output logic [2:0]    colour
);

  localparam logic [SW-1:0] DISC_LO = SW'(2);
  localparam logic [SW-1:0] DISC_HI = SW'(CELL - 3);
  localparam logic [SW-1:0] MARK_LO = SW'(CELL / 2 - 1);
  localparam logic [SW-1:0] MARK_HI = SW'(CELL / 2);

  logic in_disc;
  logic in_mark;
  logic invalid;

  assign in_disc = (sx >= DISC_LO) && (sx <= DISC_HI) &&
                   (sy >= DISC_LO) && (sy <= DISC_HI);
  assign in_mark = (sx >= MARK_LO) && (sx <= MARK_HI) &&
                   (sy >= MARK_LO) && (sy <= MARK_HI);
  assign invalid = !(code inside {CELL_EMPTY, CELL_ENABLE, CELL_WHITE, CELL_BLACK});

  // NOTE: colour gets a default before the priority chain so no path leaves
  // it unassigned; otherwise a latch would be inferred.
  always_comb begin
    colour = COL_FELT;
    if (sx == '0 || sy == '0)                colour = COL_GRID;
    else if (in_disc && code == CELL_WHITE)  colour = COL_WHITE;
    else if (in_disc && code == CELL_BLACK)  colour = COL_BLACK;
    else if (in_mark && code == CELL_ENABLE) colour = COL_MARK;
    else if (invalid)                        colour = COL_ERR;
  end

endmodule

// File: rtl/board_drawer.sv
// Raster renderer for the 8x8 reversi board on a 160x120 VGA adapter.
//   clk    : system clock
//   resetn : synchronous reset, active HIGH despite the name
//   bus    : board_drawer_if.slave (board_result/start in, pixel stream out)
// On start the board is snapshotted and 64*CELL*CELL pixels are emitted
// back-to-back in row-major screen order, followed by a one-cycle done.
module board_drawer
  import reversi_pkg::*;
#(
  parameter int ORIGIN_X = 32,
  parameter int ORIGIN_Y = 12,
  parameter int CELL     = 12
) (
  input  logic          clk,
  input  logic          resetn,
  board_drawer_if.slave bus
);

  localparam int SW = $clog2(CELL);
  localparam logic [SW-1:0] S_MAX  = SW'(CELL - 1);
  localparam logic [7:0]    OX     = 8'(ORIGIN_X);
  localparam logic [6:0]    OY     = 7'(ORIGIN_Y);
  localparam logic [7:0]    CELL_X = 8'(CELL);
  localparam logic [6:0]    CELL_Y = 7'(CELL);

  draw_state_t   state;
  logic [191:0]  snap;
  logic [2:0]    cy, cx;
  logic [SW-1:0] sy, sx;

  logic [7:0] vga_x_q;
  logic [6:0] vga_y_q;
  logic [2:0] colour_q;
  logic       plot_q, busy_q, done_q;

  // Counters hold the pixel currently on the outputs; the next pixel is
  // computed here so its colour can be registered on the same edge.
  logic [2:0]    ncy, ncx;
  logic [SW-1:0] nsy, nsx;
  logic          last_pix;
  logic [7:0]    bit_base;
  logic [2:0]    ncode;
  logic [2:0]    ncolour;
  logic [7:0]    nx;
  logic [6:0]    ny;

  always_comb begin
    nsx = sx + 1'b1;
    ncx = cx;
    nsy = sy;
    ncy = cy;
    if (sx == S_MAX) begin
      nsx = '0;
      if (cx == 3'd7) begin
        ncx = '0;
        if (sy == S_MAX) begin
          nsy = '0;
          ncy = cy + 3'd1;
        end else begin
          nsy = sy + 1'b1;
        end
      end else begin
        ncx = cx + 3'd1;
      end
    end
  end

  assign last_pix = (cy == 3'd7) && (cx == 3'd7) && (sy == S_MAX) && (sx == S_MAX);
  assign bit_base = 8'({ncy, ncx}) * 8'd3;
  assign ncode    = snap[bit_base +: 3];
  assign nx       = OX + CELL_X * 8'(ncx) + 8'(nsx);
  assign ny       = OY + CELL_Y * 7'(ncy) + 7'(nsy);

  cell_pixel_colour #(.CELL(CELL)) u_colour (
    .code   (ncode),
    .sx     (nsx),
    .sy     (nsy),
    .colour (ncolour)
  );

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: snap is pure data reloaded on every start, so it is left out of
  // the reset branch.
  always_ff @(posedge clk) begin
    if (resetn) begin
      state    <= IDLE;
      cy       <= '0;
      cx       <= '0;
      sy       <= '0;
      sx       <= '0;
      vga_x_q  <= '0;
      vga_y_q  <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            snap  <= bus.board_result;
            cy    <= '0;
            cx    <= '0;
            sy    <= '0;
            sx    <= '0;
            state <= DRAW;
            // First pixel sits on the top-left grid corner, so its colour
            // does not depend on the board being latched this edge.
            vga_x_q  <= OX;
            vga_y_q  <= OY;
            colour_q <= COL_GRID;
            plot_q   <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        DRAW: begin
          if (last_pix) begin
            state  <= FIN;
            plot_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            cy       <= ncy;
            cx       <= ncx;
            sy       <= nsy;
            sx       <= nsx;
            vga_x_q  <= nx;
            vga_y_q  <= ny;
            colour_q <= ncolour;
          end
        end
        FIN: begin
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.vga_x      = vga_x_q;
  assign bus.vga_y      = vga_y_q;
  assign bus.vga_colour = colour_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_board_drawer.sv
// Self-checking bench for board_drawer: expected pixels are generated from
// screen coordinates into a queue at start time and compared as the DUT
// plots them; framebuffer spot checks and frame/handshake checks follow.
module tb_board_drawer;
  import reversi_pkg::*;

  localparam int OX   = 32;
  localparam int OY   = 12;
  localparam int CELL = 12;
  localparam int NPIX = 64 * CELL * CELL;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic clk = 1'b0;
  logic resetn;

  board_drawer_if bus ();

  board_drawer #(.ORIGIN_X(OX), .ORIGIN_Y(OY), .CELL(CELL)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  pix_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         plot_cnt = 0;
  int         done_cnt = 0;
  logic       prev_plot = 1'b0;
  logic       mon_en = 1'b0;
  logic [14:0] last_xy;
  logic [2:0] fb [0:159][0:119];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference colour computed from screen coordinates.
  function automatic logic [2:0] model_colour(input logic [191:0] b, input int x, input int y);
    int cx, cy, sx, sy;
    logic [2:0] code;
    bit disc, mark;
    cx = (x - OX) / CELL;  sx = (x - OX) % CELL;
    cy = (y - OY) / CELL;  sy = (y - OY) % CELL;
    code = b[3 * (cy * 8 + cx) +: 3];
    disc = (sx >= 2) && (sx <= CELL - 3) && (sy >= 2) && (sy <= CELL - 3);
    mark = (sx >= CELL / 2 - 1) && (sx <= CELL / 2) && (sy >= CELL / 2 - 1) && (sy <= CELL / 2);
    if (sx == 0 || sy == 0)                          return 3'b001;
    if (disc && code == 3'b110)                      return 3'b111;
    if (disc && code == 3'b111)                      return 3'b000;
    if (mark && code == 3'b100)                      return 3'b110;
    if (code inside {3'b001, 3'b010, 3'b011, 3'b101}) return 3'b100;
    return 3'b010;
  endfunction

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      pix_t e;
      check("busy_eq_plot", 32'(bus.busy), 32'(bus.plot));
      if (bus.plot) begin
        plot_cnt++;
        last_xy = {bus.vga_x, bus.vga_y};
        if (bus.vga_x < 8'd160 && bus.vga_y < 7'd120) fb[bus.vga_x][bus.vga_y] = bus.vga_colour;
        if (sb.size() == 0) begin
          check("extra_plot", 32'(1), 32'(0));
        end else begin
          e = sb.pop_front();
          check("pixel", 32'({bus.vga_x, bus.vga_y, bus.vga_colour}), 32'(e));
        end
      end
      if (bus.done) begin
        done_cnt++;
        check("done_after_last_plot", 32'(prev_plot), 32'(1));
        check("done_plot_low", 32'(bus.plot), 32'(0));
      end
      prev_plot = bus.plot;
    end
  end

  // Called just after a falling edge; returns just after the falling edge
  // of the first pixel cycle.
  task automatic start_frame(input logic [191:0] b);
    pix_t p;
    for (int y = OY; y < OY + 8 * CELL; y++)
      for (int x = OX; x < OX + 8 * CELL; x++) begin
        p.x = 8'(x);
        p.y = 7'(y);
        p.c = model_colour(b, x, y);
        sb.push_back(p);
      end
    plot_cnt = 0;
    done_cnt = 0;
    bus.board_result = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("first_plot", 32'(bus.plot), 32'(1));
    check("first_xy", 32'({bus.vga_x, bus.vga_y}), 32'({8'(OX), 7'(OY)}));
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < NPIX + 20; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'(1));
  endtask

  // Called one cycle after done.
  task automatic end_checks();
    check("plot_count", 32'(plot_cnt), 32'(NPIX));
    check("sb_empty", 32'(sb.size()), 32'(0));
    check("last_xy", 32'(last_xy), 32'({8'(OX + 8 * CELL - 1), 7'(OY + 8 * CELL - 1)}));
    check("done_pulses", 32'(done_cnt), 32'(1));
    check("done_one_cycle", 32'(bus.done), 32'(0));
  endtask

  logic [191:0] b_init, b_mod;

  initial begin
    int n, d0;
    bus.board_result = '0;
    bus.start = 1'b0;
    b_init = '0;
    b_init[3 * 27 +: 3] = 3'b110;
    b_init[3 * 28 +: 3] = 3'b111;
    b_init[3 * 35 +: 3] = 3'b111;
    b_init[3 * 36 +: 3] = 3'b110;
    b_mod = b_init;
    b_mod[3 * 0 +: 3]  = 3'b100;
    b_mod[3 * 63 +: 3] = 3'b011;

    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_x", 32'(bus.vga_x), 32'(0));
    check("rst_y", 32'(bus.vga_y), 32'(0));
    check("rst_colour", 32'(bus.vga_colour), 32'(0));
    check("rst_plot", 32'(bus.plot), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    resetn = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Frame 1: power-up board
    start_frame(b_init);
    wait_done();
    @(negedge clk);
    end_checks();
    check("px_73_53", 32'(fb[73][53]), 32'(3'b111));
    check("px_73_65", 32'(fb[73][65]), 32'(3'b000));
    check("px_37_17", 32'(fb[37][17]), 32'(3'b010));
    check("px_32_12", 32'(fb[32][12]), 32'(3'b001));
    repeat (2) @(negedge clk);

    // Frame 2: marker and invalid code; start coincident with done ignored
    start_frame(b_mod);
    wait_done();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    end_checks();
    check("start_at_done_plot", 32'(bus.plot), 32'(0));
    check("start_at_done_busy", 32'(bus.busy), 32'(0));
    check("mk_37_17", 32'(fb[37][17]), 32'(3'b110));
    check("mk_38_18", 32'(fb[38][18]), 32'(3'b110));
    check("mk_36_16", 32'(fb[36][16]), 32'(3'b010));
    check("err_125_105", 32'(fb[125][105]), 32'(3'b100));
    check("grid_116_96", 32'(fb[116][96]), 32'(3'b001));
    repeat (2) @(negedge clk);

    // Frame 3: board toggled and start pulsed mid-frame
    start_frame(b_mod);
    repeat (3000) @(negedge clk);
    bus.board_result = ~b_mod;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    @(negedge clk);
    end_checks();
    repeat (2) @(negedge clk);

    // Frame 4: reset at pixel 5000, then full redraw
    start_frame(b_init);
    n = 1;
    for (int i = 0; i < NPIX && n < 5000; i++) begin
      @(negedge clk);
      if (bus.plot) n++;
    end
    check("reached_5000", 32'(n), 32'(5000));
    resetn = 1'b1;
    @(negedge clk);
    check("mid_rst_plot", 32'(bus.plot), 32'(0));
    check("mid_rst_busy", 32'(bus.busy), 32'(0));
    check("mid_rst_done", 32'(bus.done), 32'(0));
    sb.delete();
    resetn = 1'b0;
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    check("no_done_after_rst", 32'(done_cnt), 32'(d0));
    check("idle_after_rst", 32'(bus.plot), 32'(0));
    start_frame(b_init);
    wait_done();
    @(negedge clk);
    end_checks();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/board_drawer.md
# board_drawer

Raster renderer directly downstream of the reversi board state machine. On a `start` pulse it snapshots the 192-bit `board_result` (64 cells × 3 bits) and emits one pixel per clock to the 160×120 VGA adapter. Each pixel carries coordinates, a 3-bit RGB colour and a `plot` strobe. It draws the 8×8 grid, the white and black discs, and the legal-move markers.

## Interface
Parameters:
- `ORIGIN_X`, default 32: screen x of the board's top-left pixel.
- `ORIGIN_Y`, default 12: screen y of the board's top-left pixel.
- `CELL`, default 12: cell edge length in pixels.
- Constraints: `CELL` ≥ 8, `ORIGIN_X`+8·`CELL` ≤ 160, `ORIGIN_Y`+8·`CELL` ≤ 120.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `resetn` in 1: synchronous, active-high reset. Despite the name, `resetn`=1 resets.
- `board_result` in 192: cell i (i = row·8 + col) occupies bits [3i+2:3i].
- `start` in 1: one-cycle request to redraw the board.
- `vga_x` out 8: pixel x.
- `vga_y` out 7: pixel y.
- `vga_colour` out 3: RGB colour of the pixel.
- `plot` out 1: write strobe for the pixel on `vga_x`/`vga_y`/`vga_colour`.
- `busy` out 1: a frame is being drawn.
- `done` out 1: one-cycle pulse after the last pixel.

## Operation
- FSM states: IDLE, DRAW, FIN.
  - IDLE: when `start`=1, latch `board_result` into `snap`, clear the counters and go to DRAW.
  - DRAW: emit one pixel per cycle. After the last pixel, go to FIN.
  - FIN: assert `done` for one cycle, then return to IDLE.
- Scan order is row-major over the whole board using four counters:
  - `cy` (3 b, cell row), `sy` (0..CELL-1, row inside the cell), `cx` (3 b, cell column), `sx` (0..CELL-1, column inside the cell).
  - `sx` is the innermost counter.
  - `vga_x` = ORIGIN_X + cx·CELL + sx; `vga_y` = ORIGIN_Y + cy·CELL + sy.
- Cell codes, for cell (cy,cx) taken from `snap`: 000 EMPTY, 100 ENABLE, 110 WHITE, 111 BLACK.
- Colour rules, first match wins:
  - Grid: sx==0 or sy==0 → 001 (blue).
  - Disc region: sx,sy both in [2, CELL-3]. WHITE → 111, BLACK → 000.
  - Marker region: sx,sy both in [CELL/2-1, CELL/2]. ENABLE → 110 (yellow).
  - Invalid code (001, 010, 011, 101): whole non-grid area → 100 (red).
  - Everything else → 010 (green felt).
- The right and bottom outer edges get no closing grid line.
- Ignored inputs:
  - `start` while in DRAW or FIN is ignored, with no queuing.
  - Changes to `board_result` after the latch do not affect the frame in progress.

## Timing
- All outputs are registered.
- Reset values: `vga_x`=0, `vga_y`=0, `vga_colour`=000, `plot`=0, `busy`=0, `done`=0. State returns to IDLE and all counters are cleared.
- `start` sampled at edge N:
  - The first pixel, (ORIGIN_X, ORIGIN_Y) with colour 001, is valid with `plot`=1 during cycle N+1.
  - Pixels follow back-to-back for 64·CELL² cycles (9216 with default parameters).
  - The last pixel, (ORIGIN_X+8·CELL-1, ORIGIN_Y+8·CELL-1), is in cycle N+9216.
- `busy`=1 exactly during cycles N+1..N+9216, i.e. whenever `plot`=1.
- `done`=1 in cycle N+9217, with `plot`=0 in that cycle.
- `start` coincident with `done` is ignored. A new `start` is accepted from cycle N+9218.
- Reset mid-frame: the next cycle has `plot`=0 and `busy`=0, `done` is not pulsed, and the partial frame is abandoned.
- Coordinate adders use 8-bit (x) and 7-bit (y) results. The parameter constraints guarantee no overflow.

## Structure
- Package `reversi_pkg` holds:
  - cell codes CELL_EMPTY, CELL_ENABLE, CELL_WHITE, CELL_BLACK;
  - colours COL_GRID, COL_FELT, COL_WHITE, COL_BLACK, COL_MARK, COL_ERR;
  - the FSM state encodings.
- Combinational sub-module `cell_pixel_colour`: inputs are the 3-bit code, `sx`, `sy` and `CELL`; output is the 3-bit colour.
- Top level contains the FSM, counters, snapshot register, cell-select mux (`snap[3i +: 3]`) and output registers.

## Test plan
- Reset, then `start` with the power-up board, which has: idx 27 = 110, idx 28 = 111, idx 35 = 111, idx 36 = 110, all others 000.
  - Pixel (73,53) is 111, pixel (73,65) is 000, pixel (37,17) is 010, pixel (32,12) is 001.
- Full frame count: exactly 9216 `plot` cycles, last at (127,107). `done` is high for exactly one cycle, the cycle after the last plot. `busy` equals `plot` throughout.
- Set idx 0 to 100: pixels (37,17) and (38,18) are 110, pixel (36,16) is 010. Set idx 63 to 011: pixel (125,105) is 100 and pixel (116,96) is 001.
- Pulse `start` again and toggle all of `board_result` mid-frame:
  - the frame is unchanged;
  - no restart occurs;
  - the total is still 9216 plots.
- Assert `resetn` at pixel 5000: `plot`, `busy` and `done` are 0 from the next cycle, and no `done` pulse appears. A subsequent `start` redraws from (32,12).
